// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : uart_pkg
//  Purpose  : Shared UART definitions: receiver FSM state encoding, bit-timing
//             constants and the baud divider helper. Shared by the receive
//             and transmit paths.
//  Ports    : none (package)
//  Revision : 1.0  initial release
// ============================================================================
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_START = 3'd1,
        ST_DATA  = 3'd2,
        ST_STOP  = 3'd3,
        ST_BREAK = 3'd4
    } uart_state_t;

    localparam int OVERSAMPLE = 16;   // ticks per bit, fixed
    localparam int MID_TICK   = 7;    // tick index at the middle of the start bit
    localparam int FRAME_BITS = 8;    // data bits per frame

    // Clocks per oversample tick, truncated and never allowed below one.
    function automatic int baud_div(input int clk_freq, input int baud);
        int d;
        d = clk_freq / (baud * OVERSAMPLE);
        return (d < 1) ? 1 : d;
    endfunction

endpackage
`default_nettype wire

// File: rtl/uart_baud_tick.sv
`default_nettype none
// ============================================================================
//  Module   : uart_baud_tick
//  Purpose  : Free-running oversample tick generator. Emits a one-cycle pulse
//             every DIV clocks; 'restart' zeroes the counter so the tick phase
//             lines up with an incoming start bit.
//  Ports    : clk      in   system clock
//             reset    in   synchronous, active-low
//             restart  in   zero the divider counter
//             tick     out  one-cycle pulse every DIV clocks
//  Revision : 1.0  initial release
// ============================================================================
module uart_baud_tick
    import uart_pkg::*;
#(
    parameter int CLK_FREQ = 50_000_000,
    parameter int BAUD     = 9600
) (
    input  logic clk,
    input  logic reset,
    input  logic restart,
    output logic tick
);

    localparam int DIV   = baud_div(CLK_FREQ, BAUD);
    localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CNT_W-1:0] c_last = CNT_W'(DIV - 1);

    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (!reset || restart) begin
            r_cnt <= '0;
        end else if (r_cnt == c_last) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    // With DIV=1 the counter sits at zero and this is high every cycle.
    assign tick = (r_cnt == c_last);

endmodule
`default_nettype wire

// File: rtl/uart_receiver.sv
`default_nettype none
// ============================================================================
//  Module   : uart_receiver
//  Purpose  : 8N1 UART receiver, LSB first, 16x oversampling. Holds one byte
//             for the Peripheral block with sticky valid/overrun/framing flags.
//  Ports    : clk        in   system clock
//             reset      in   synchronous, active-low
//             rx_in      in   asynchronous serial line, idles high
//             rd_ack     in   data-register read pulse, clears the flags
//             rx_data    out  last good byte received
//             rx_valid   out  unread byte present
//             rx_overrun out  byte completed while rx_valid was set
//             frame_err  out  stop bit sampled low
//             busy       out  FSM not in IDLE
//  Revision : 1.0  initial release
// ============================================================================
module uart_receiver
    import uart_pkg::*;
#(
    parameter int CLK_FREQ = 50_000_000,
    parameter int BAUD     = 9600
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rx_in,
    input  logic       rd_ack,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       rx_overrun,
    output logic       frame_err,
    output logic       busy
);

    localparam logic [3:0] c_mid_tick  = 4'(MID_TICK);
    localparam logic [3:0] c_last_tick = 4'(OVERSAMPLE - 1);
    localparam logic [2:0] c_last_bit  = 3'(FRAME_BITS - 1);

    uart_state_t r_state;
    logic        r_sync1;
    logic        r_sync2;
    logic        r_sync_prev;
    logic [3:0]  r_tick_cnt;
    logic [2:0]  r_bit_idx;
    logic [7:0]  r_shift;
    logic [7:0]  r_rx_data;
    logic        r_rx_valid;
    logic        r_rx_overrun;
    logic        r_frame_err;
    logic        r_busy;

    logic        w_fall;
    logic        w_restart;
    logic        w_tick;

    assign w_fall    = r_sync_prev & ~r_sync2;
    // Re-phase the divider on the detected start edge.
    assign w_restart = (r_state == ST_IDLE) && w_fall;

    uart_baud_tick #(
        .CLK_FREQ (CLK_FREQ),
        .BAUD     (BAUD)
    ) u_baud_tick (
        .clk     (clk),
        .reset   (reset),
        .restart (w_restart),
        .tick    (w_tick)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_sync1      <= 1'b1;
            r_sync2      <= 1'b1;
            r_sync_prev  <= 1'b1;
            r_state      <= ST_IDLE;
            r_tick_cnt   <= '0;
            r_bit_idx    <= '0;
            r_shift      <= '0;
            r_rx_data    <= 8'h00;
            r_rx_valid   <= 1'b0;
            r_rx_overrun <= 1'b0;
            r_frame_err  <= 1'b0;
            r_busy       <= 1'b0;
        end else begin
            r_sync1     <= rx_in;
            r_sync2     <= r_sync1;
            r_sync_prev <= r_sync2;

            // A read clears the flags; a frame completing in the same cycle
            // overrides these below.
            if (rd_ack) begin
                r_rx_valid   <= 1'b0;
                r_rx_overrun <= 1'b0;
                r_frame_err  <= 1'b0;
            end

            case (r_state)
                ST_IDLE: begin
                    if (w_fall) begin
                        r_state    <= ST_START;
                        r_tick_cnt <= '0;
                        r_busy     <= 1'b1;
                    end
                end

                ST_START: begin
                    if (w_tick) begin
                        if (r_tick_cnt == c_mid_tick) begin
                            if (r_sync2) begin
                                // Line back high at mid-start: glitch.
                                r_state <= ST_IDLE;
                                r_busy  <= 1'b0;
                            end else begin
                                r_state    <= ST_DATA;
                                r_tick_cnt <= '0;
                                r_bit_idx  <= '0;
                            end
                        end else begin
                            r_tick_cnt <= r_tick_cnt + 1'b1;
                        end
                    end
                end

                ST_DATA: begin
                    if (w_tick) begin
                        if (r_tick_cnt == c_last_tick) begin
                            r_tick_cnt         <= '0;
                            r_shift[r_bit_idx] <= r_sync2;
                            if (r_bit_idx == c_last_bit) begin
                                r_state <= ST_STOP;
                            end else begin
                                r_bit_idx <= r_bit_idx + 1'b1;
                            end
                        end else begin
                            r_tick_cnt <= r_tick_cnt + 1'b1;
                        end
                    end
                end

                ST_STOP: begin
                    if (w_tick) begin
                        if (r_tick_cnt == c_last_tick) begin
                            r_tick_cnt <= '0;
                            if (r_sync2) begin
                                r_rx_data  <= r_shift;
                                r_rx_valid <= 1'b1;
                                if (r_rx_valid && !rd_ack) begin
                                    r_rx_overrun <= 1'b1;
                                end
                                r_state <= ST_IDLE;
                                r_busy  <= 1'b0;
                            end else begin
                                r_frame_err <= 1'b1;
                                r_state     <= ST_BREAK;
                            end
                        end else begin
                            r_tick_cnt <= r_tick_cnt + 1'b1;
                        end
                    end
                end

                ST_BREAK: begin
                    // Held low after a bad stop bit; no start detection here.
                    if (r_sync2) begin
                        r_state <= ST_IDLE;
                        r_busy  <= 1'b0;
                    end
                end

                default: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign rx_data    = r_rx_data;
    assign rx_valid   = r_rx_valid;
    assign rx_overrun = r_rx_overrun;
    assign frame_err  = r_frame_err;
    assign busy       = r_busy;

endmodule
`default_nettype wire
